asm_reg_master: RTL and testbench
=================================

// Module: asm_reg_master
// PURPOSE
//  Initiator side of the accelerator-domain config register bus (config_en/wben/addr/wdata/rdata).
//  Accepts register read/write requests on a valid/ready request channel and buffers them in a small FIFO.
//  Issues one bus access per request to the register-file responder and returns one response per request.
//  Sits between the TCU/ASM control path and the accelerator register file; one access outstanding at a time.
// PARAMETERS
//  TCU_REG_DATA_SIZE  64  data width of bus and request/response data
//  TCU_REG_ADDR_SIZE  32  register byte address width
//  TCU_REG_BSEL_SIZE  8   byte-enable width (TCU_REG_DATA_SIZE/8)
//  READ_LATENCY       1   cycles from config_en_o (read) to valid config_rdata_i; legal 1..4
//  REQ_FIFO_DEPTH     2   request FIFO entries; power of two, >=2
// PORTS
//  clk_i           in   1      clock
//  reset_i         in   1      synchronous reset, active-high
//  req_valid_i     in   1      request valid
//  req_ready_o     out  1      request FIFO not full
//  req_write_i     in   1      1=write, 0=read
//  req_addr_i      in   ADDR   register byte address
//  req_wdata_i     in   DATA   write data
//  req_bsel_i      in   BSEL   write byte enables (ignored for reads)
//  rsp_valid_o     out  1      response valid
//  rsp_ready_i     in   1      response accepted
//  rsp_write_o     out  1      response belongs to a write
//  rsp_rdata_o     out  DATA   read data (0 for writes)
//  config_en_o     out  1      bus access strobe
//  config_wben_o   out  BSEL   byte enables; all-zero = read
//  config_addr_o   out  ADDR   bus address
//  config_wdata_o  out  DATA   bus write data
//  config_rdata_i  in   DATA   responder read data (registered in responder)
//  busy_o          out  1      FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (reset_i=1 at posedge): FSM=IDLE, FIFO empty, all outputs 0 except req_ready_o=1.
//  Request accepted on req_valid_i&&req_ready_o at a posedge; req_ready_o=0 only when FIFO full.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE: FIFO non-empty -> pop head into bus/command regs -> ISSUE (or RESP, see bsel=0).
//   ISSUE: config_en_o=1 exactly this cycle; write -> RESP; read -> WAIT (READ_LATENCY=1: sample at end of ISSUE+1).
//   WAIT: counter from READ_LATENCY-1 down; capture config_rdata_i into rsp_rdata_o in cycle ISSUE+READ_LATENCY -> RESP.
//   RESP: rsp_valid_o=1, held stable with rsp_write_o/rsp_rdata_o until rsp_ready_i; then -> IDLE.
//  Outside ISSUE: config_en_o=0, config_wben_o=0; addr/wdata hold last issued values.
//  Reads always drive config_wben_o=0; writes drive req_bsel_i.
//  Write with req_bsel_i==0: no bus access (would alias to a read); IDLE -> RESP directly, rsp_write_o=1.
//  Write response: rsp_rdata_o=0. Responses strictly in request order.
//  Timing: accept in cycle 0 -> ISSUE cycle 2 -> write rsp_valid_o cycle 3; read rsp_valid_o cycle 3+READ_LATENCY.
//  FIFO push and pop in same cycle allowed when full (pop frees slot, but req_ready_o from registered count: no push when full).
//  rsp_ready_i stuck low: FSM stays in RESP, FIFO keeps accepting until full, no further bus access.
//  Reset mid-operation (any state): transaction dropped, no response, config_en_o=0 from next cycle.
//  Pointer wrap: FIFO read/write pointers carry one extra bit for full/empty distinction.
// STRUCTURE
//  Shared header: FSM state encoding, request-entry field offsets/width (write+addr+data+bsel).
//  Sub-module asm_reg_req_fifo: synchronous FIFO (push/pop/full/empty, registered count).
//  Top: FSM, latency counter, bus output regs, response regs.
// TESTING
//  Write addr 0x0, data 0x1, bsel 0x01 -> config_en_o=1 one cycle at cycle 2 with wben=0x01; rsp_valid_o cycle 3, rsp_write_o=1, rdata 0.
//  Read addr 0x28, responder model returns 0x40000 one cycle after en -> rsp_rdata_o=0x40000, rsp_write_o=0 in cycle 4.
//  Write addr 0x18, bsel 0x00 -> config_en_o never asserted; rsp_valid_o with rsp_write_o=1.
//  3 back-to-back reads, rsp_ready_i=0 for 10 cycles -> req_ready_o=0 after FIFO full; one config_en_o only; responses in order after release.
//  READ_LATENCY=3, read 0x58 -> rdata sampled exactly 3 cycles after config_en_o; earlier stale value 0xDEAD ignored.
//  reset_i=1 during WAIT -> next cycle rsp_valid_o=0, config_en_o=0, busy_o=0, req_ready_o=1; no late response.

Source files
------------

// File: rtl/asm_reg_master_pkg.sv
// Shared definitions for the accelerator config-register bus initiator:
// FSM state encoding and the packed layout of a queued request.
package asm_reg_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // A request entry is packed as {write, addr, wdata, bsel}, bsel in the LSBs.
   function automatic int entry_width(int addr_w, int data_w, int bsel_w);
      return 1 + addr_w + data_w + bsel_w;
   endfunction

   function automatic int data_lsb(int bsel_w);
      return bsel_w;
   endfunction

   function automatic int addr_lsb(int data_w, int bsel_w);
      return bsel_w + data_w;
   endfunction

   function automatic int write_bit(int addr_w, int data_w, int bsel_w);
      return bsel_w + data_w + addr_w;
   endfunction

endpackage

// File: rtl/asm_reg_master_req_fifo.sv
// Request FIFO for asm_reg_master: synchronous push/pop, pointers carry a
// wrap bit for empty detection, full comes from a registered occupancy count.
module asm_reg_req_fifo #(
   parameter int WIDTH = 105,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign head_o  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/asm_reg_master.sv
// Config-register bus initiator: queues read/write requests, issues one bus
// access at a time to the register file and returns responses in order.
module asm_reg_master
   import asm_reg_master_pkg::*;
#(
   parameter int TCU_REG_DATA_SIZE = 64,
   parameter int TCU_REG_ADDR_SIZE = 32,
   parameter int TCU_REG_BSEL_SIZE = 8,
   parameter int READ_LATENCY      = 1,
   parameter int REQ_FIFO_DEPTH    = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_write_i,
   input  logic [TCU_REG_ADDR_SIZE-1:0] req_addr_i,
   input  logic [TCU_REG_DATA_SIZE-1:0] req_wdata_i,
   input  logic [TCU_REG_BSEL_SIZE-1:0] req_bsel_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic                         rsp_write_o,
   output logic [TCU_REG_DATA_SIZE-1:0] rsp_rdata_o,
   output logic                         config_en_o,
   output logic [TCU_REG_BSEL_SIZE-1:0] config_wben_o,
   output logic [TCU_REG_ADDR_SIZE-1:0] config_addr_o,
   output logic [TCU_REG_DATA_SIZE-1:0] config_wdata_o,
   input  logic [TCU_REG_DATA_SIZE-1:0] config_rdata_i,
   output logic                         busy_o
);
   localparam int A         = TCU_REG_ADDR_SIZE;
   localparam int D         = TCU_REG_DATA_SIZE;
   localparam int B         = TCU_REG_BSEL_SIZE;
   localparam int ENTRY_W   = entry_width(A, D, B);
   localparam int DATA_LSB  = data_lsb(B);
   localparam int ADDR_LSB  = addr_lsb(D, B);
   localparam int WRITE_BIT = write_bit(A, D, B);
   localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

   state_t       r_state;
   logic [1:0]   r_lat_cnt;
   logic         r_is_write;
   logic         r_config_en;
   logic [B-1:0] r_config_wben;
   logic [A-1:0] r_config_addr;
   logic [D-1:0] r_config_wdata;
   logic         r_rsp_valid;
   logic         r_rsp_write;
   logic [D-1:0] r_rsp_rdata;

   logic [ENTRY_W-1:0] w_push_data;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_head_write;
   logic [A-1:0]       w_head_addr;
   logic [D-1:0]       w_head_wdata;
   logic [B-1:0]       w_head_bsel;

   assign w_push_data  = {req_write_i, req_addr_i, req_wdata_i, req_bsel_i};
   assign w_head_write = w_head[WRITE_BIT];
   assign w_head_addr  = w_head[ADDR_LSB +: A];
   assign w_head_wdata = w_head[DATA_LSB +: D];
   assign w_head_bsel  = w_head[0 +: B];
   assign w_pop        = (r_state == ST_IDLE) && !w_empty;

   asm_reg_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (REQ_FIFO_DEPTH)
   ) u_req_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (req_valid_i),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state        <= ST_IDLE;
         r_lat_cnt      <= '0;
         r_is_write     <= 1'b0;
         r_config_en    <= 1'b0;
         r_config_wben  <= '0;
         r_config_addr  <= '0;
         r_config_wdata <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_write    <= 1'b0;
         r_rsp_rdata    <= '0;
      end else begin
         r_config_en   <= 1'b0;
         r_config_wben <= '0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  // A zero byte-enable write would look like a read on the bus.
                  if (w_head_write && (w_head_bsel == '0)) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_write <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_config_en    <= 1'b1;
                     r_config_wben  <= w_head_write ? w_head_bsel : '0;
                     r_config_addr  <= w_head_addr;
                     r_config_wdata <= w_head_wdata;
                     r_is_write     <= w_head_write;
                     r_state        <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (r_is_write) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= ST_RESP;
               end else begin
                  r_lat_cnt <= LAT_INIT;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt == 2'd0) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= 1'b0;
                  r_rsp_rdata <= config_rdata_i;
                  r_state     <= ST_RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 2'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o    = !w_full;
   assign rsp_valid_o    = r_rsp_valid;
   assign rsp_write_o    = r_rsp_write;
   assign rsp_rdata_o    = r_rsp_rdata;
   assign config_en_o    = r_config_en;
   assign config_wben_o  = r_config_wben;
   assign config_addr_o  = r_config_addr;
   assign config_wdata_o = r_config_wdata;
   assign busy_o         = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_asm_reg_master.sv
// Bench for asm_reg_master: directed timing scenarios plus randomized traffic
// checked against a request-level register-file model and response queue.
module tb_asm_reg_master;
   localparam logic [63:0] VAL3 = 64'h0000_5858_CAFE_0058;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_valid3 = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_bsel = '0;
   logic        rsp_ready = 1'b1, rsp_ready3 = 1'b1;
   logic [63:0] cfg_rdata = '0, cfg_rdata3 = 64'hDEAD;
   logic        req_ready, rsp_valid, rsp_write, cfg_en, busy;
   logic [63:0] rsp_rdata, cfg_wdata;
   logic [7:0]  cfg_wben;
   logic [31:0] cfg_addr;
   logic        req_ready3, rsp_valid3, rsp_write3, cfg_en3, busy3;
   logic [63:0] rsp_rdata3, cfg_wdata3;
   logic [7:0]  cfg_wben3;
   logic [31:0] cfg_addr3;

   int n_vec = 0;
   int n_err = 0;
   int en_count = 0;

   logic [64:0]  exp_q[$];       // {write, rdata}
   logic [103:0] exp_bus_q[$];   // {wben, addr, wdata}
   logic [63:0]  model_mem[logic [31:0]];
   logic [63:0]  bus_mem[logic [31:0]];

   always #5 clk = ~clk;

   asm_reg_master #(.READ_LATENCY(1)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_bsel_i(req_bsel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
      .rsp_rdata_o(rsp_rdata), .config_en_o(cfg_en), .config_wben_o(cfg_wben),
      .config_addr_o(cfg_addr), .config_wdata_o(cfg_wdata),
      .config_rdata_i(cfg_rdata), .busy_o(busy)
   );

   asm_reg_master #(.READ_LATENCY(3)) dut3 (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_bsel_i(req_bsel),
      .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_write_o(rsp_write3),
      .rsp_rdata_o(rsp_rdata3), .config_en_o(cfg_en3), .config_wben_o(cfg_wben3),
      .config_addr_o(cfg_addr3), .config_wdata_o(cfg_wdata3),
      .config_rdata_i(cfg_rdata3), .busy_o(busy3)
   );

   function automatic logic [63:0] default_val(logic [31:0] a);
      return {~a, a};
   endfunction

   function automatic logic [63:0] merge(logic [63:0] old_v, logic [63:0] new_v, logic [7:0] be);
      logic [63:0] r = old_v;
      for (int i = 0; i < 8; i++)
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] model_rd(logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : default_val(a);
   endfunction

   function automatic logic [63:0] bus_rd(logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : default_val(a);
   endfunction

   // Register-file responder, read data registered one cycle after the strobe.
   initial forever begin
      @(negedge clk);
      if (cfg_en && !reset) begin
         if (cfg_wben == 8'h00) begin
            logic [63:0] v;
            v = bus_rd(cfg_addr);
            @(posedge clk); #1;
            cfg_rdata = v;
         end else begin
            bus_mem[cfg_addr] = merge(bus_rd(cfg_addr), cfg_wdata, cfg_wben);
         end
      end
   end

   // Three-cycle responder: stale data everywhere except the exact return cycle.
   initial forever begin
      @(negedge clk);
      if (cfg_en3 && !reset) begin
         repeat (3) begin @(posedge clk); #1; end
         cfg_rdata3 = VAL3;
         @(posedge clk); #1;
         cfg_rdata3 = 64'hDEAD;
      end
   end

   // Bus and response scoreboard.
   initial forever begin
      @(negedge clk);
      if (cfg_en) begin
         en_count++;
         n_vec++;
         if (exp_bus_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: addr=%h wben=%h, no access expected", cfg_addr, cfg_wben);
         end else begin
            logic [103:0] e;
            e = exp_bus_q.pop_front();
            if (cfg_wben !== e[103:96] || cfg_addr !== e[95:64] ||
                (e[103:96] != 8'h00 && cfg_wdata !== e[63:0])) begin
               n_err++;
               $display("FAIL bus_access: got wben=%h addr=%h wdata=%h, expected wben=%h addr=%h wdata=%h",
                        cfg_wben, cfg_addr, cfg_wdata, e[103:96], e[95:64], e[63:0]);
            end
         end
      end
      if (rsp_valid && rsp_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: write=%b rdata=%h, no response expected", rsp_write, rsp_rdata);
         end else begin
            logic [64:0] e;
            e = exp_q.pop_front();
            if ({rsp_write, rsp_rdata} !== e) begin
               n_err++;
               $display("FAIL rsp_order: got write=%b rdata=%h, expected write=%b rdata=%h",
                        rsp_write, rsp_rdata, e[64], e[63:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called right after a posedge; returns right after the accepting posedge.
   task automatic push(input logic wr, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] be);
      int guard = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_bsel = be;
      @(negedge clk);
      while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!req_ready) begin
         n_vec++; n_err++;
         $display("FAIL push_timeout: req_ready=%b, required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (wr) begin
         exp_q.push_back({1'b1, 64'h0});
         if (be != 8'h00) begin
            exp_bus_q.push_back({be, a, wd});
            model_mem[a] = merge(model_rd(a), wd, be);
         end
      end else begin
         exp_q.push_back({1'b0, model_rd(a)});
         exp_bus_q.push_back({8'h00, a, wd});
      end
   endtask

   task automatic drain();
      int guard = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && guard < 300) begin @(negedge clk); guard++; end
      n_vec++;
      if (exp_q.size() != 0 || busy) begin
         n_err++;
         $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, cfg_en, cfg_wben, cfg_addr, cfg_wdata, rsp_write, rsp_rdata, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b en=%b wben=%h addr=%h wdata=%h write=%b rdata=%h busy=%b, required all 0",
                  rsp_valid, cfg_en, cfg_wben, cfg_addr, cfg_wdata, rsp_write, rsp_rdata, busy);
      end
      n_vec++;
      if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: req_ready=%b req_ready3=%b, required 1", req_ready, req_ready3);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_write();
      push(1'b1, 32'h0, 64'h1, 8'h01);
      @(negedge clk);
      n_vec++;
      if (cfg_en !== 1'b0) begin
         n_err++; $display("FAIL wr_en_c1: config_en=%b, required 0", cfg_en);
      end
      @(negedge clk);
      n_vec++;
      if (cfg_en !== 1'b1 || cfg_wben !== 8'h01 || cfg_addr !== 32'h0 || cfg_wdata !== 64'h1) begin
         n_err++;
         $display("FAIL wr_issue_c2: en=%b wben=%h addr=%h wdata=%h, required 1 01 0 1", cfg_en, cfg_wben, cfg_addr, cfg_wdata);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 64'h0 || cfg_en !== 1'b0) begin
         n_err++;
         $display("FAIL wr_rsp_c3: valid=%b write=%b rdata=%h en=%b, required 1 1 0 0", rsp_valid, rsp_write, rsp_rdata, cfg_en);
      end
      drain();
   endtask

   task automatic test_read();
      push(1'b0, 32'h28, 64'h0, 8'h00);
      repeat (2) @(negedge clk);
      n_vec++;
      if (cfg_en !== 1'b1 || cfg_wben !== 8'h00 || cfg_addr !== 32'h28) begin
         n_err++;
         $display("FAIL rd_issue_c2: en=%b wben=%h addr=%h, required 1 00 28", cfg_en, cfg_wben, cfg_addr);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rd_early_c3: rsp_valid=%b, required 0", rsp_valid);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 64'h40000) begin
         n_err++;
         $display("FAIL rd_rsp_c4: valid=%b write=%b rdata=%h, required 1 0 40000", rsp_valid, rsp_write, rsp_rdata);
      end
      drain();
   endtask

   task automatic test_bsel_zero();
      int e0 = en_count;
      int guard = 0;
      push(1'b1, 32'h18, 64'h1234, 8'h00);
      @(negedge clk);
      while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 64'h0) begin
         n_err++;
         $display("FAIL bsel0_rsp: valid=%b write=%b rdata=%h, required 1 1 0", rsp_valid, rsp_write, rsp_rdata);
      end
      drain();
      n_vec++;
      if (en_count != e0) begin
         n_err++; $display("FAIL bsel0_no_access: bus strobes=%0d, required 0", en_count - e0);
      end
   endtask

   task automatic test_back_to_back();
      int e0;
      rsp_ready = 1'b0;
      e0 = en_count;
      push(1'b0, 32'h40, 64'h0, 8'h00);
      push(1'b0, 32'h48, 64'h0, 8'h00);
      push(1'b0, 32'h50, 64'h0, 8'h00);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_err++; $display("FAIL b2b_full: req_ready=%b, required 0", req_ready);
      end
      repeat (10) @(negedge clk);
      n_vec++;
      if (en_count - e0 != 1 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_stall: strobes=%0d ready=%b rsp_valid=%b busy=%b, required 1 0 1 1",
                  en_count - e0, req_ready, rsp_valid, busy);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();
   endtask

   task automatic test_latency3();
      int t_en = -1;
      int t_rsp = -1;
      int n_en = 0;
      logic [63:0] seen = '0;
      req_write = 1'b0; req_addr = 32'h58; req_bsel = 8'h00; req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (cfg_en3) begin n_en++; t_en = t; end
         if (rsp_valid3 && t_rsp < 0) begin t_rsp = t; seen = rsp_rdata3; end
      end
      n_vec++;
      if (n_en != 1 || cfg_addr3 !== 32'h58) begin
         n_err++; $display("FAIL lat3_strobe: strobes=%0d addr=%h, required 1 58", n_en, cfg_addr3);
      end
      n_vec++;
      if (t_rsp - t_en != 4 || seen !== VAL3) begin
         n_err++;
         $display("FAIL lat3_capture: rsp %0d cycles after strobe rdata=%h, required 4 %h", t_rsp - t_en, seen, VAL3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic late = 1'b0;
      push(1'b0, 32'h30, 64'h0, 8'h00);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      exp_bus_q.delete();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || cfg_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid: rsp_valid=%b en=%b busy=%b ready=%b, required 0 0 0 1", rsp_valid, cfg_en, busy, req_ready);
      end
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid || cfg_en) late = 1'b1;
      end
      n_vec++;
      if (late !== 1'b0) begin
         n_err++; $display("FAIL reset_late_rsp: late activity=%b, required 0", late);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic        wr;
               logic [7:0]  be;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               wr = 1'($urandom_range(0, 1));
               be = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
               push(wr, {25'h0, 4'($urandom_range(0, 15)), 3'b000}, {$urandom, $urandom}, be);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      drain();
   endtask

   initial begin
      model_mem[32'h28] = 64'h40000;
      bus_mem[32'h28]   = 64'h40000;
      test_reset();
      test_write();
      test_read();
      test_bsel_zero();
      test_back_to_back();
      test_latency3();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
